// File: rtl/ibex_instr_realign_pkg.sv
// rtl/ibex_instr_realign_pkg.sv - shared constants and types for the fetch realignment stage
package ibex_instr_realign_pkg;

  // Default number of 16-bit halfword slots in the realignment buffer.
  localparam int unsigned IbexRealignHwDepth = 4;

  // One buffered halfword together with the bus error of the word it came from.
  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } realign_entry_t;

endpackage

// File: rtl/ibex_instr_realign.sv
// rtl/ibex_instr_realign.sv - halfword buffer that turns word fetches into whole instructions
module ibex_instr_realign
  import ibex_instr_realign_pkg::*;
#(
  parameter int unsigned HwDepth = IbexRealignHwDepth
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned PtrW = $clog2(HwDepth);
  localparam int unsigned CntW = $clog2(HwDepth + 1);
  // A full word needs two free slots, so accept only while count leaves room for both.
  localparam logic [CntW-1:0] MaxFillForWord = CntW'(HwDepth - 2);
  localparam logic [PtrW:0]   DepthWide      = (PtrW + 1)'(HwDepth);

  realign_entry_t hw_q [HwDepth];

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:1]     pc_q;
  logic            discard_q;

  realign_entry_t  head, next, in_lo, in_hi;
  logic [PtrW-1:0] rd_ptr_plus1, wr_ptr_plus1;
  logic            comp, single, have_one, have_two;
  logic            push, pop;
  logic [1:0]      push_cnt, pop_cnt;

  // Bit 0 of the redirect target carries no information for halfword-aligned PCs.
  logic unused_clear_addr_bit;
  assign unused_clear_addr_bit = clear_addr_i[0];

  // Pointer advance by 0..2 slots, wrapping at HwDepth (which need not be a power of two).
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr, input logic [1:0] amt);
    logic [PtrW:0] sum;
    sum = {1'b0, ptr} + {{(PtrW - 1){1'b0}}, amt};
    if (sum >= DepthWide) sum = sum - DepthWide;
    return sum[PtrW-1:0];
  endfunction

  assign rd_ptr_plus1 = wrap_add(rd_ptr_q, 2'd1);
  assign wr_ptr_plus1 = wrap_add(wr_ptr_q, 2'd1);

  assign head = hw_q[rd_ptr_q];
  assign next = hw_q[rd_ptr_plus1];

  assign in_lo = '{data: in_rdata_i[15:0],  err: in_err_i};
  assign in_hi = '{data: in_rdata_i[31:16], err: in_err_i};

  // A faulted head halfword is issued alone so the error is reported at its own PC.
  assign comp     = (head.data[1:0] != 2'b11);
  assign single   = comp | head.err;
  assign have_one = (count_q != '0);
  assign have_two = (count_q >= CntW'(2));

  assign in_ready_o  = (count_q <= MaxFillForWord) & !clear_i;
  assign out_valid_o = !clear_i & ((have_one & single) | have_two);
  assign out_instr_o = single ? {16'h0000, head.data} : {next.data, head.data};
  assign out_err_o   = head.err | (!comp & !head.err & next.err);
  assign out_addr_o  = {pc_q, 1'b0};

  // Both handshakes are already masked by clear_i through the ready/valid terms above.
  assign push     = in_valid_i & in_ready_o;
  assign pop      = out_valid_o & out_ready_i;
  assign push_cnt = push ? (discard_q ? 2'd1 : 2'd2) : 2'd0;
  assign pop_cnt  = pop ? (single ? 2'd1 : 2'd2) : 2'd0;

  // Pointers, occupancy, PC and the discard-low-half flag; redirect overrides everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pc_q      <= '0;
      discard_q <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pc_q      <= clear_addr_i[31:1];
      discard_q <= clear_addr_i[1];
    end else begin
      rd_ptr_q <= wrap_add(rd_ptr_q, pop_cnt);
      wr_ptr_q <= wrap_add(wr_ptr_q, push_cnt);
      count_q  <= count_q + CntW'(push_cnt) - CntW'(pop_cnt);
      pc_q     <= pc_q + 31'(pop_cnt);
      if (push) discard_q <= 1'b0;
    end
  end

  // Halfword storage; after a redirect into the upper half only that half is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(HwDepth); i++) hw_q[i] <= '0;
    end else if (push) begin
      if (discard_q) begin
        hw_q[wr_ptr_q] <= in_hi;
      end else begin
        hw_q[wr_ptr_q]     <= in_lo;
        hw_q[wr_ptr_plus1] <= in_hi;
      end
    end
  end

endmodule
